// File: rtl/aes_stream_ctrl_if.sv
// Bundle of the configuration, plaintext/ciphertext streams and encrypt-core
// operand signals seen by aes_stream_ctrl.
interface aes_stream_ctrl_if;
  logic         cfg_we;
  logic [2:0]   cfg_addr;
  logic [31:0]  cfg_wdata;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         busy;
  logic         core_start;
  logic [127:0] core_plain_text;
  logic [127:0] core_key;
  logic [127:0] core_cipher_text;
  logic         core_finish;
  logic         core_bus_free;

  modport master (
    input  cfg_we, cfg_addr, cfg_wdata,
    input  in_valid, in_data, out_ready,
    input  core_cipher_text, core_finish, core_bus_free,
    output in_ready, out_valid, out_data, busy,
    output core_start, core_plain_text, core_key
  );

  modport slave (
    output cfg_we, cfg_addr, cfg_wdata,
    output in_valid, in_data, out_ready,
    output core_cipher_text, core_finish, core_bus_free,
    input  in_ready, out_valid, out_data, busy,
    input  core_start, core_plain_text, core_key
  );
endinterface

// File: rtl/aes_stream_ctrl.sv
// Streams 32-bit plaintext words into 128-bit blocks for an AES encrypt core
// (ECB, or CBC when CBC_EN=1) and streams the ciphertext back out as words.
module aes_stream_ctrl #(
  parameter bit CBC_EN = 1'b0
) (
  input logic               clk,
  input logic               rst,
  aes_stream_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [127:0] in_buf_q;
  logic [127:0] out_buf_q;
  logic [127:0] pt_q;
  logic [127:0] key_q;
  logic [127:0] iv_q;
  logic [127:0] chain_q;
  logic [2:0]   count_q;
  logic [2:0]   out_count_q;
  logic         busy;
  logic         in_fire;
  logic         out_fire;
  logic         out_drained;
  logic         enter_start;
  logic         capture;
  logic         cfg_ok;
  logic [127:0] iv_upd;
  logic         unused_bus_free;

  function automatic logic [127:0] put_word(input logic [127:0] v,
                                            input logic [1:0]   idx,
                                            input logic [31:0]  w);
    logic [127:0] r;
    r = v;
    case (idx)
      2'd0:    r[127:96] = w;
      2'd1:    r[95:64]  = w;
      2'd2:    r[63:32]  = w;
      default: r[31:0]   = w;
    endcase
    return r;
  endfunction

  assign bus.in_ready        = (count_q < 3'd4);
  assign bus.out_valid       = (out_count_q != 3'd0);
  assign bus.out_data        = out_buf_q[127:96];
  assign busy                = (state_q != IDLE) || (out_count_q != 3'd0);
  assign bus.busy            = busy;
  assign bus.core_start      = (state_q == START);
  assign bus.core_plain_text = pt_q;
  assign bus.core_key        = key_q;

  assign in_fire     = bus.in_valid && bus.in_ready;
  assign out_fire    = bus.out_valid && bus.out_ready;
  // Output buffer is empty now or becomes empty on this edge.
  assign out_drained = (out_count_q == 3'd0) || ((out_count_q == 3'd1) && bus.out_ready);
  assign enter_start = (state_q == IDLE) && (state_d == START);
  assign capture     = (state_q == RUN) && bus.core_finish;
  assign cfg_ok      = bus.cfg_we && !busy && (count_q == 3'd0);
  assign iv_upd      = put_word(iv_q, bus.cfg_addr[1:0], bus.cfg_wdata);
  assign unused_bus_free = bus.core_bus_free;

  // Block sequencing: launch when a full block waits and results have drained.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if ((count_q == 3'd4) && out_drained) state_d = START;
        else                                  state_d = IDLE;
      end
      START: state_d = RUN;
      RUN: begin
        if (bus.core_finish) state_d = IDLE;
        else                 state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Input assembly and core operand latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_buf_q <= 128'd0;
      count_q  <= 3'd0;
      pt_q     <= 128'd0;
    end else if (enter_start) begin
      pt_q    <= CBC_EN ? (in_buf_q ^ chain_q) : in_buf_q;
      count_q <= 3'd0;
    end else if (in_fire) begin
      in_buf_q <= {in_buf_q[95:0], bus.in_data};
      count_q  <= count_q + 3'd1;
    end
  end

  // Result capture and word-wise drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_buf_q   <= 128'd0;
      out_count_q <= 3'd0;
    end else if (capture) begin
      out_buf_q   <= bus.core_cipher_text;
      out_count_q <= 3'd4;
    end else if (out_fire) begin
      out_buf_q   <= {out_buf_q[95:0], 32'd0};
      out_count_q <= out_count_q - 3'd1;
    end
  end

  // Key, IV and CBC chaining value; config is locked out while a block is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q   <= 128'd0;
      iv_q    <= 128'd0;
      chain_q <= 128'd0;
    end else begin
      if (cfg_ok && !bus.cfg_addr[2]) begin
        key_q <= put_word(key_q, bus.cfg_addr[1:0], bus.cfg_wdata);
      end
      if (CBC_EN && capture) begin
        chain_q <= bus.core_cipher_text;
      end else if (CBC_EN && cfg_ok && bus.cfg_addr[2]) begin
        iv_q    <= iv_upd;
        chain_q <= iv_upd;
      end
    end
  end

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Drives an ECB and a CBC instance with identical stimulus; a behavioural AES
// core stub answers both, and expected ciphertext comes from an AES-128 model.
module tb_aes_stream_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_stream_ctrl_if bus_e();
  aes_stream_ctrl_if bus_c();

  aes_stream_ctrl #(.CBC_EN(1'b0)) u_ecb (.clk(clk), .rst(rst), .bus(bus_e));
  aes_stream_ctrl #(.CBC_EN(1'b1)) u_cbc (.clk(clk), .rst(rst), .bus(bus_c));

  assign bus_c.cfg_we        = bus_e.cfg_we;
  assign bus_c.cfg_addr      = bus_e.cfg_addr;
  assign bus_c.cfg_wdata     = bus_e.cfg_wdata;
  assign bus_c.in_valid      = bus_e.in_valid;
  assign bus_c.in_data       = bus_e.in_data;
  assign bus_c.out_ready     = bus_e.out_ready;
  assign bus_c.core_bus_free = bus_e.core_bus_free;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [7:0] sbox_t [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] st;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]}
              ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    st = pt ^ {w[0], w[1], w[2], w[3]};
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_t[st[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) t[rr + 4*c] = s[rr + 4*((c + rr) % 4)];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 10) begin
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) st[127-8*i -: 8] = s[i];
      st = st ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    return st;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Encrypt-core stub: finish rises 13 cycles after start, cleared by the next start.
  logic [3:0]   ce_cnt = 4'd0, cc_cnt = 4'd0;
  logic         ce_fin = 1'b0, cc_fin = 1'b0;
  logic [127:0] ce_res = 128'd0, cc_res = 128'd0;
  assign bus_e.core_finish      = ce_fin;
  assign bus_e.core_cipher_text = ce_res;
  assign bus_c.core_finish      = cc_fin;
  assign bus_c.core_cipher_text = cc_res;

  always @(posedge clk) begin
    if (bus_e.core_start) begin
      ce_cnt <= 4'd12;
      ce_fin <= 1'b0;
      ce_res <= aes_enc(bus_e.core_plain_text, bus_e.core_key);
    end else if (ce_cnt != 4'd0) begin
      ce_cnt <= ce_cnt - 4'd1;
      if (ce_cnt == 4'd1) ce_fin <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (bus_c.core_start) begin
      cc_cnt <= 4'd12;
      cc_fin <= 1'b0;
      cc_res <= aes_enc(bus_c.core_plain_text, bus_c.core_key);
    end else if (cc_cnt != 4'd0) begin
      cc_cnt <= cc_cnt - 4'd1;
      if (cc_cnt == 4'd1) cc_fin <= 1'b1;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: start/rise timestamps and in-order output word checking.
  int          starts[$];
  int          rises[$];
  logic        ov_prev = 1'b0;
  logic [31:0] exp_e[$];
  logic [31:0] exp_c[$];

  always @(negedge clk) begin
    if (bus_e.core_start) starts.push_back(cyc);
    if (bus_e.out_valid && !ov_prev) rises.push_back(cyc);
    ov_prev <= bus_e.out_valid;
    if (bus_e.out_valid && bus_e.out_ready) begin
      chki("ecb_word_expected", int'(exp_e.size() != 0), 1);
      if (exp_e.size() != 0) chk("ecb_word", 128'(bus_e.out_data), 128'(exp_e.pop_front()));
    end
    if (bus_c.out_valid && bus_c.out_ready) begin
      chki("cbc_word_expected", int'(exp_c.size() != 0), 1);
      if (exp_c.size() != 0) chk("cbc_word", 128'(bus_c.out_data), 128'(exp_c.pop_front()));
    end
  end

  logic [127:0] key_ref = 128'd0;
  logic [127:0] iv_ref = 128'd0;
  logic [127:0] chain_ref = 128'd0;
  logic         rnd_ready = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_ready) bus_e.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
    bus_e.cfg_we    = 1'b1;
    bus_e.cfg_addr  = a;
    bus_e.cfg_wdata = d;
    step();
    bus_e.cfg_we = 1'b0;
  endtask

  task automatic cfg_write_idle(input logic [2:0] a, input logic [31:0] d);
    int g = 0;
    while (bus_e.busy && g < 500) begin step(); g++; end
    chki("cfg_idle", int'(bus_e.busy), 0);
    cfg_write(a, d);
    if (!a[2]) key_ref[127-32*int'(a[1:0]) -: 32] = d;
    else begin
      iv_ref[127-32*int'(a[1:0]) -: 32] = d;
      chain_ref = iv_ref;
    end
  endtask

  task automatic send_word(input logic [31:0] d, input int gap);
    int g = 0;
    bus_e.in_valid = 1'b0;
    for (int i = 0; i < gap; i++) step();
    bus_e.in_valid = 1'b1;
    bus_e.in_data  = d;
    while (!bus_e.in_ready && g < 200) begin step(); g++; end
    chki("in_accept", int'(g < 200), 1);
    step();
    bus_e.in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] blk, input int max_gap);
    for (int w = 0; w < 4; w++) send_word(blk[127-32*w -: 32], int'($urandom_range(0, max_gap)));
  endtask

  task automatic push_exp(input logic [127:0] ce, input logic [127:0] cc);
    for (int w = 0; w < 4; w++) begin
      exp_e.push_back(ce[127-32*w -: 32]);
      exp_c.push_back(cc[127-32*w -: 32]);
    end
  endtask

  task automatic model_block(input logic [127:0] blk);
    logic [127:0] cc;
    cc = aes_enc(blk ^ chain_ref, key_ref);
    chain_ref = cc;
    push_exp(aes_enc(blk, key_ref), cc);
  endtask

  task automatic wait_start(input int n);
    int g = 0;
    while (starts.size() <= n && g < 200) begin step(); g++; end
    chki("start_seen", int'(starts.size() > n), 1);
  endtask

  task automatic wait_quiet();
    int g = 0;
    while ((exp_e.size() != 0 || exp_c.size() != 0 || bus_e.busy) && g < 3000) begin step(); g++; end
    chki("drain", int'(g < 3000), 1);
  endtask

  logic [127:0] fips_key, fips_pt, fips_ct, blk;
  int n0, r0, s0, g;

  initial begin
    for (int v = 0; v < 256; v++) begin
      logic [7:0] inv;
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(v));
      sbox_t[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    fips_key = 128'h000102030405060708090a0b0c0d0e0f;
    fips_pt  = 128'h00112233445566778899aabbccddeeff;
    fips_ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    bus_e.cfg_we = 1'b0; bus_e.cfg_addr = 3'd0; bus_e.cfg_wdata = 32'd0;
    bus_e.in_valid = 1'b0; bus_e.in_data = 32'd0;
    bus_e.out_ready = 1'b1; bus_e.core_bus_free = 1'b1;

    repeat (3) step();
    chki("rst_in_ready", int'(bus_e.in_ready), 1);
    chki("rst_out_valid", int'(bus_e.out_valid), 0);
    chki("rst_busy", int'(bus_e.busy), 0);
    chki("rst_core_start", int'(bus_e.core_start), 0);
    chk("rst_core_key", bus_c.core_key, 128'd0);
    chk("rst_core_pt", bus_c.core_plain_text, 128'd0);
    @(negedge clk) rst = 1'b0;
    step();

    for (int a = 0; a < 4; a++) cfg_write_idle(3'(a), fips_key[127-32*a -: 32]);
    for (int a = 4; a < 8; a++) cfg_write_idle(3'(a), 32'd0);
    chk("key_loaded_ecb", bus_e.core_key, fips_key);
    chk("key_loaded_cbc", bus_c.core_key, fips_key);

    // FIPS-197 block: literal expected ciphertext and start-to-valid latency.
    n0 = starts.size(); r0 = rises.size();
    send_block(fips_pt, 0);
    push_exp(fips_ct, fips_ct);
    chain_ref = fips_ct;
    wait_start(n0);
    g = 0;
    while (rises.size() <= r0 && g < 100) begin step(); g++; end
    chki("rise_seen", int'(rises.size() > r0), 1);
    if (rises.size() > r0 && starts.size() > n0) chki("latency", rises[r0] - starts[n0], 14);
    wait_quiet();

    // Same block again: CBC operand must be chained with the first ciphertext.
    n0 = starts.size();
    send_block(fips_pt, 0);
    model_block(fips_pt);
    wait_start(n0);
    chki("start_one_cycle", int'(bus_e.core_start), 0);
    chk("cbc_pt2", bus_c.core_plain_text, 128'h00112233445566778899aabbccddeeff ^ 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    chk("ecb_pt2", bus_e.core_plain_text, fips_pt);
    wait_quiet();

    // Overlap: next block fed during RUN starts as soon as the output drains.
    n0 = starts.size();
    blk = {$urandom(), $urandom(), $urandom(), $urandom()};
    send_block(blk, 0); model_block(blk);
    wait_start(n0);
    blk = {$urandom(), $urandom(), $urandom(), $urandom()};
    send_block(blk, 0); model_block(blk);
    wait_start(n0 + 1);
    if (starts.size() > n0 + 1) chki("spacing", starts[n0+1] - starts[n0], 18);
    wait_quiet();

    // Back-pressure: out_ready low for 40 cycles after first out_valid.
    n0 = starts.size(); r0 = rises.size();
    blk = {$urandom(), $urandom(), $urandom(), $urandom()};
    send_block(blk, 1); model_block(blk);
    wait_start(n0);
    bus_e.out_ready = 1'b0;
    g = 0;
    while (rises.size() <= r0 && g < 100) begin step(); g++; end
    chki("bp_rise_seen", int'(rises.size() > r0), 1);
    blk = {$urandom(), $urandom(), $urandom(), $urandom()};
    send_block(blk, 0); model_block(blk);
    s0 = cyc;
    while (rises.size() > r0 && cyc < rises[r0] + 40 && cyc < s0 + 60) step();
    chki("bp_in_ready_low", int'(bus_e.in_ready), 0);
    chki("bp_no_start", starts.size(), n0 + 1);
    chki("bp_out_valid_held", int'(bus_e.out_valid), 1);
    chk("bp_top_word", 128'(bus_e.out_data), 128'(exp_e[0]));
    bus_e.out_ready = 1'b1;
    wait_start(n0 + 1);
    wait_quiet();

    // Config lockout during RUN, and while a partial block is buffered.
    n0 = starts.size();
    blk = {$urandom(), $urandom(), $urandom(), $urandom()};
    send_block(blk, 0); model_block(blk);
    wait_start(n0);
    cfg_write(3'd0, 32'hdeadbeef);
    cfg_write(3'd4, 32'hcafef00d);
    chk("lock_key_ecb", bus_e.core_key, key_ref);
    chk("lock_key_cbc", bus_c.core_key, key_ref);
    wait_quiet();
    blk = {$urandom(), $urandom(), $urandom(), $urandom()};
    send_word(blk[127:96], 0);
    cfg_write(3'd1, 32'h12345678);
    chk("partial_lock_key", bus_c.core_key, key_ref);
    for (int w = 1; w < 4; w++) send_word(blk[127-32*w -: 32], 0);
    model_block(blk);
    wait_quiet();

    // Asynchronous reset at S+6 abandons the block.
    n0 = starts.size();
    blk = {$urandom(), $urandom(), $urandom(), $urandom()};
    send_block(blk, 0);
    wait_start(n0);
    if (starts.size() > n0) s0 = starts[n0]; else s0 = cyc;
    while (cyc < s0 + 6) step();
    chki("pre_rst_busy", int'(bus_e.busy), 1);
    #2 rst = 1'b1;
    #1;
    chki("arst_out_valid", int'(bus_c.out_valid), 0);
    chki("arst_in_ready", int'(bus_c.in_ready), 1);
    chki("arst_busy", int'(bus_c.busy), 0);
    chki("arst_core_start", int'(bus_c.core_start), 0);
    chk("arst_core_key", bus_c.core_key, 128'd0);
    chk("arst_core_pt", bus_c.core_plain_text, 128'd0);
    step(); step();
    @(negedge clk) rst = 1'b0;
    key_ref = 128'd0; iv_ref = 128'd0; chain_ref = 128'd0;
    r0 = rises.size();
    repeat (30) step();
    chki("rst_no_out", rises.size(), r0);

    // Randomized traffic with new key/IV and random back-pressure.
    for (int a = 0; a < 8; a++) cfg_write_idle(3'(a), $urandom());
    rnd_ready = 1'b1;
    for (int b = 0; b < 6; b++) begin
      blk = {$urandom(), $urandom(), $urandom(), $urandom()};
      send_block(blk, 2);
      model_block(blk);
    end
    wait_quiet();
    rnd_ready = 1'b0;
    bus_e.out_ready = 1'b1;
    chki("exp_ecb_empty", exp_e.size(), 0);
    chki("exp_cbc_empty", exp_c.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_stream_ctrl.md
AES_STREAM_CTRL -- requirements
Module: aes_stream_ctrl

Interface
REQ-001 Parameter CBC_EN, default 0, meaning: 1 selects CBC chaining, 0 selects ECB.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 cfg_we  in  1  config write strobe.
REQ-005 cfg_addr  in  3  0-3 = key words, 4-7 = IV words; word 0/4 maps to bits [127:96].
REQ-006 cfg_wdata  in  32  config write data.
REQ-007 in_valid, in_ready  in/out  1/1  plaintext word handshake.
REQ-008 in_data  in  32  plaintext word; the first word of a block maps to [127:96].
REQ-009 out_valid, out_ready  out/in  1/1  ciphertext word handshake.
REQ-010 out_data  out  32  ciphertext word; [127:96] is sent first.
REQ-011 busy  out  1  high whenever state != IDLE or the output buffer is non-empty.
REQ-012 core_start  out  1  one-cycle start pulse to the encrypt core.
REQ-013 core_plain_text, core_key  out  128/128  registered operands to the core.
REQ-014 core_cipher_text  in  128  core result.
REQ-015 core_finish  in  1  core done, level signal.
REQ-016 core_bus_free  in  1  unused; operands are held for the whole operation.

Function
REQ-017 Input buffer: 128 bits plus a 3-bit word count (0-4); a word is accepted when in_valid && in_ready; in_ready = (count < 4).
REQ-018 State machine: IDLE -> START when count == 4 and the output buffer is empty; START -> RUN unconditionally; RUN -> IDLE when core_finish == 1.
REQ-019 On the edge entering START:
- core_plain_text <= in_buf ^ chain when CBC_EN=1, else in_buf.
- count <= 0.
REQ-020 in_ready is high from the cycle after START, so input of the next block overlaps RUN.
REQ-021 core_start = (state == START); it is high for exactly one cycle per block.
REQ-022 RUN ignores core_finish in no cycle before S+1, where S is the start cycle; core_finish is low at S+1 because the core restarts.
REQ-023 In RUN, when core_finish is high (cycle S+13):
- output buffer <= core_cipher_text and out_count <= 4.
- chain <= core_cipher_text when CBC_EN=1.
REQ-024 Output: out_valid = (out_count != 0); out_data = the current top word; each out handshake shifts the buffer left 32 bits and decrements out_count.
REQ-025 Latency: out_valid first rises at S+14; with no back-pressure the minimum start-to-start spacing is 18 cycles.
REQ-026 core_key and core_plain_text are held constant from S through the end of RUN.
REQ-027 cfg writes take effect only when busy == 0 and count == 0; otherwise they are silently dropped.
REQ-028 A key write updates core_key directly. An IV write updates the IV register and also loads chain from the updated IV.
REQ-029 IV writes are ignored when CBC_EN=0; chain is unused in that mode.
REQ-030 Simultaneous input accept and entry to START: the accepted word is dropped.
- This cannot occur legally because in_ready is 0 when count == 4.
- If the bench forces it, in_ready stays 0.
REQ-031 A new block is never started while out_count != 0. Back-pressure on out_ready stalls START, and then stalls input once count reaches 4.

Reset
REQ-032 On rst high, asynchronously:
- state = IDLE; count = 0; out_count = 0.
- in_buf, output buffer, core_plain_text, core_key, IV and chain = 0.
- core_start = 0; out_valid = 0; in_ready = 1; busy = 0.
REQ-033 Reset mid-RUN abandons the block; no out_valid follows until a full new block is supplied.

Verification
REQ-034 ECB FIPS-197:
- Stimulus: key 000102030405060708090a0b0c0d0e0f; words 00112233, 44556677, 8899aabb, ccddeeff; core connected.
- Response: out words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a; first out_valid exactly 14 cycles after core_start.
REQ-035 CBC (CBC_EN=1):
- Stimulus: IV = 0, same key, the same plaintext block sent twice.
- Response: block 1 ciphertext as in REQ-034; block 2 core_plain_text = 00112233...ccddeeff ^ 69c4e0d8...70b4c55a.
REQ-036 Back-pressure:
- Stimulus: out_ready held low for 40 cycles after the first out_valid; second block fully input.
- Response: no core_start during the stall; in_ready low once count = 4; data is intact after release.
REQ-037 Config lockout:
- Stimulus: a key write during RUN.
- Response: core_key unchanged; the result equals the original-key ciphertext.
REQ-038 Async reset:
- Stimulus: rst asserted at S+6 mid-RUN.
- Response: all outputs are at their REQ-032 values in the same cycle, with no later out_valid.
REQ-039 Overlap:
- Stimulus: four words delivered during RUN.
- Response: the next core_start is issued at the first cycle after the output buffer empties.
